key_schedule_seq: RTL and testbench
===================================

Name: key_schedule_seq

Overview:
- Sequential AES key-expansion engine for 128/192/256-bit keys, selected by parameter.
- Generates one 32-bit schedule word per clock and packs every four words into a 128-bit round key.
- Delivers round keys in order over a valid/ready handshake to the round datapath.
- Performs the G step (RotWord, SubWord, Rcon) internally with a sequenced Rcon, plus the AES-256 H step (SubWord only).

Parameters:
- NK, 4, key length in 32-bit words; legal values 4, 6, 8. Any other value is a synthesis error.
- NR, NK+6, number of rounds (derived localparam, not overridable).
- TOTAL_WORDS, 4*(NR+1), schedule length in words: 44, 52 or 60 (derived).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin expansion; sampled only in IDLE.
- key_in  in  32*NK  cipher key; word 0 in the MSBs. Captured on an accepted start.
- rk_ready  in  1  consumer accepts rk_data this cycle.
- rk_valid  out  1  rk_data/rk_index valid.
- rk_data  out  128  round key; first word of the group in bits [127:96].
- rk_index  out  4  round number of rk_data, 0..NR.
- busy  out  1  high from the accepted start until the final round key is accepted.
- done  out  1  one-cycle pulse on the edge after the final round key is accepted.

Behaviour:
- Reset values (asynchronous): all outputs 0, FSM in IDLE. Internal state is also cleared: word counter i=0, Rcon=0x01, key window, assembly buffer. Reset mid-operation aborts the run; no partial keys are emitted afterwards.
- FSM states:
  - IDLE: start=1 -> captures key_in into an NK-word window, i=0, Rcon=0x01, busy=1 -> GEN.
  - GEN: produces word w[i] per cycle unless stalled. After w[TOTAL_WORDS-1] is produced -> DRAIN.
  - DRAIN: waits until the last key is accepted, then done=1, busy=0 -> IDLE.
  - start in GEN or DRAIN is ignored.
- Word rule:
  - i<NK: w[i] = key word i.
  - Otherwise w[i] = w[i-NK] ^ temp, where:
    - temp = SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0} when i%NK==0;
    - temp = SubWord(w[i-1]) when NK==8 and i%NK==4;
    - temp = w[i-1] in all other cases.
- RotWord is a left byte rotation. SubWord uses a single shared s_box_flex #(4) instance (combinational).
- Rcon advances after each i%NK==0 word (i>=NK) as xtime: 01,02,04,08,10,20,40,80,1B,36.
- The window is a shift register of the last NK words; i wraps never; the counter width covers 0..59.
- Packing: each word shifts into a 4-word assembly buffer. The edge that writes a word with i%4==3 copies the full buffer into the rk_data register, sets rk_valid=1 and rk_index=i/4.
- Handshake:
  - Transfer occurs when rk_valid && rk_ready.
  - rk_valid drops on the transfer edge unless a new group loads on the same edge; in that case rk_valid stays 1 with the new data.
  - rk_data and rk_index are stable while rk_valid && !rk_ready.
- Stall: in a cycle where i%4==3 and rk_valid && !rk_ready, no word is produced; i and the window hold.
- Throughput: with rk_ready tied high, one round key every 4 cycles.
- Latency: start accepted at edge E0. Word w[k] is written at E(k+1). Round key r is valid after edge E(4r+4). The final key is valid after E(TOTAL_WORDS); done pulses after the acceptance edge.
- Simultaneous events: acceptance plus new-group load on the same edge -> new key takes the register with no bubble. Reset dominates every other input.

Test Plan:
- NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rk_index 0 = key. rk_index 1 = a0fafe1788542cb123a339392a6c7605, valid 8 cycles after start. rk_index 10 = d014f9a8c9ee2589e13f0cc8b6630ca6. done pulses exactly once; 11 keys total.
- NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> word 6 (rk_index 1, bits [63:32]) = fe0c91f7. rk_index 12 = e98ba06f448c773c8ecc720401002202; 13 keys total.
- NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk_index 2 = 9ba354118e6925afa51a8b5f2067fcde. Word 12 = a8b09c1a (H path). rk_index 14 = fe4890d1e6188d0b046df344706c631e.
- NK=4 backpressure: rk_ready low for 10 cycles while rk_index 1 is valid -> rk_data/rk_index held, generation stalls at i=11. After release, the sequence is identical to the no-stall run and done is delayed by the stall length.
- start pulsed during GEN, and rst asserted when rk_index=5 is valid -> the extra start is ignored. Reset immediately clears rk_valid/busy/done to 0. A new start then yields rk_index 0 = new key.
- rk_ready toggling 1/0 every cycle -> no key lost or duplicated; rk_index strictly increments 0..NR.

Source files
------------

// File: rtl/key_schedule_if.sv
// Round-key delivery interface between the key-schedule engine and the
// round datapath. "master" is the side that starts the expansion and
// consumes round keys; "slave" is the key-schedule engine itself.
interface key_schedule_if #(
  parameter int NK = 4
);
  logic              start;
  logic [32*NK-1:0]  key_in;
  logic              rk_ready;
  logic              rk_valid;
  logic [127:0]      rk_data;
  logic [3:0]        rk_index;
  logic              busy;
  logic              done;

  modport master (
    output start, key_in, rk_ready,
    input  rk_valid, rk_data, rk_index, busy, done
  );

  modport slave (
    input  start, key_in, rk_ready,
    output rk_valid, rk_data, rk_index, busy, done
  );
endinterface

// File: rtl/key_schedule_seq.sv
// Sequential AES key expansion (AES-128/192/256 chosen by NK).
// One 32-bit schedule word per clock; every four words are packed into a
// 128-bit round key and offered over a valid/ready handshake.

// Combinational AES S-box applied to N bytes in parallel. Each byte is
// computed as the GF(2^8) inverse followed by the affine transform, so no
// lookup table has to be maintained.
module s_box_flex #(
  parameter int N = 4
) (
  input  logic [8*N-1:0] din,
  output logic [8*N-1:0] dout
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    // x^254 is the multiplicative inverse; it also maps 0 to 0 as AES needs.
    sq = x;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  for (genvar b = 0; b < N; b++) begin : g_byte
    assign dout[8*b +: 8] = sbox(din[8*b +: 8]);
  end
endmodule

module key_schedule_seq #(
  parameter int NK = 4
) (
  input  logic           clk,
  input  logic           rst,
  key_schedule_if.slave  bus
);
  localparam int NR          = NK + 6;
  localparam int TOTAL_WORDS = 4 * (NR + 1);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("key_schedule_seq: NK must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

  state_t           state;
  logic [5:0]       i;        // index of the next word to produce
  logic [2:0]       j;        // i mod NK, kept as its own counter
  logic [7:0]       rcon;
  logic [32*NK-1:0] win;      // last NK words, oldest (w[i-NK]) in the MSBs
  logic [95:0]      asm_buf;  // previous three words of the current group

  logic [31:0] oldest, prev, sub_in, sub_out, temp, w_new;
  logic        past_key, is_g, is_h, stall, produce, group_end, last_word;

  // While i<NK the window is rotated, so its top word walks through the
  // captured key and the window holds the key again once i reaches NK.
  assign oldest = win[32*NK-1 -: 32];
  assign prev   = win[31:0];

  s_box_flex #(.N(4)) u_sbox (.din(sub_in), .dout(sub_out));

  // Next-word datapath: G step on i%NK==0, H step (NK=8) on i%NK==4.
  always_comb begin
    // NOTE: every signal gets a value on every path, so no latch is inferred.
    past_key  = (i >= 6'(NK));
    is_g      = past_key && (j == 3'd0);
    is_h      = (NK == 8) && past_key && (j == 3'd4);
    sub_in    = is_g ? {prev[23:0], prev[31:24]} : prev;
    temp      = prev;
    if (is_g)      temp = sub_out ^ {rcon, 24'h0};
    else if (is_h) temp = sub_out;
    w_new     = past_key ? (oldest ^ temp) : oldest;
    group_end = (i[1:0] == 2'd3);
    stall     = group_end && bus.rk_valid && !bus.rk_ready;
    produce   = (state == GEN) && !stall;
    last_word = (i == 6'(TOTAL_WORDS - 1));
  end

  // Control FSM, word generation, packing and handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      i            <= '0;
      j            <= '0;
      rcon         <= 8'h01;
      // NOTE: the window and buffer are cleared too, so an aborted run leaves
      // no trace of the previous key in the registers.
      win          <= '0;
      asm_buf      <= '0;
      bus.rk_valid <= 1'b0;
      bus.rk_data  <= '0;
      bus.rk_index <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; later assignments in this block
      // override the defaults set here.
      bus.done <= 1'b0;
      if (bus.rk_valid && bus.rk_ready) bus.rk_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            win      <= bus.key_in;
            i        <= '0;
            j        <= '0;
            rcon     <= 8'h01;
            bus.busy <= 1'b1;
            state    <= GEN;
          end
        end
        GEN: begin
          if (produce) begin
            win     <= {win[32*NK-33:0], w_new};
            asm_buf <= {asm_buf[63:0], w_new};
            i       <= i + 6'd1;
            j       <= (j == 3'(NK - 1)) ? 3'd0 : j + 3'd1;
            if (is_g) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            if (group_end) begin
              bus.rk_data  <= {asm_buf, w_new};
              bus.rk_index <= i[5:2];
              bus.rk_valid <= 1'b1;
            end
            if (last_word) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.rk_valid && bus.rk_ready) begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_key_schedule_seq.sv
// Bench for key_schedule_seq: three instances (NK=4/6/8) checked against
// published AES key-expansion vectors, plus backpressure, abort and
// toggling-ready sequences on the AES-128 instance.
module tb_key_schedule_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  key_schedule_if #(.NK(4)) if4 ();
  key_schedule_if #(.NK(6)) if6 ();
  key_schedule_if #(.NK(8)) if8 ();

  key_schedule_seq #(.NK(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  key_schedule_seq #(.NK(6)) u_dut6 (.clk(clk), .rst(rst), .bus(if6));
  key_schedule_seq #(.NK(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

  localparam logic [127:0] KEY4  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY4B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] KEY6  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KEY8  =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] FULL  = {128{1'b1}};
  localparam logic [127:0] W2    = 128'h0000_0000_0000_0000_ffff_ffff_0000_0000;
  localparam logic [127:0] W0    = 128'hffff_ffff_0000_0000_0000_0000_0000_0000;

  // Accepted transfers, recorded on the falling edge before the transfer edge.
  typedef struct {int nk; int idx; logic [127:0] data; int cyc;} rec_t;
  rec_t recs[$];
  int   done_cnt [3] = '{0, 0, 0};
  int   done_cyc [3] = '{0, 0, 0};

  always @(negedge clk) begin
    if (if4.rk_valid && if4.rk_ready)
      recs.push_back(rec_t'{nk: 4, idx: int'(if4.rk_index), data: if4.rk_data, cyc: cyc});
    if (if6.rk_valid && if6.rk_ready)
      recs.push_back(rec_t'{nk: 6, idx: int'(if6.rk_index), data: if6.rk_data, cyc: cyc});
    if (if8.rk_valid && if8.rk_ready)
      recs.push_back(rec_t'{nk: 8, idx: int'(if8.rk_index), data: if8.rk_data, cyc: cyc});
    if (if4.done) begin done_cnt[0] <= done_cnt[0] + 1; done_cyc[0] <= cyc; end
    if (if6.done) begin done_cnt[1] <= done_cnt[1] + 1; done_cyc[1] <= cyc; end
    if (if8.done) begin done_cnt[2] <= done_cnt[2] + 1; done_cyc[2] <= cyc; end
  end

  typedef struct {int nk; int idx; logic [127:0] mask; logic [127:0] exp;} vec_t;
  vec_t vt[$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Per-run view of the recorded transfers.
  logic [127:0] got [3][15];
  int           got_n [3];
  bit           order_ok [3];
  int           rk1_cyc;

  task automatic scan(input int base);
    int s;
    for (int a = 0; a < 3; a++) begin
      got_n[a]    = 0;
      order_ok[a] = 1'b1;
      for (int k = 0; k < 15; k++) got[a][k] = 'x;
    end
    rk1_cyc = -1;
    for (int q = base; q < recs.size(); q++) begin
      s = recs[q].nk / 2 - 2;
      if (recs[q].idx != got_n[s]) order_ok[s] = 1'b0;
      if (recs[q].idx < 15) got[s][recs[q].idx] = recs[q].data;
      if (recs[q].nk == 4 && recs[q].idx == 1) rk1_cyc = recs[q].cyc;
      got_n[s]++;
    end
  endtask

  task automatic apply_table(input int nk_sel, input string tag);
    int s;
    foreach (vt[v]) begin
      if (vt[v].nk == nk_sel) begin
        s = vt[v].nk / 2 - 2;
        check($sformatf("%s_nk%0d_rk%0d", tag, vt[v].nk, vt[v].idx),
              got[s][vt[v].idx] & vt[v].mask, vt[v].exp & vt[v].mask);
      end
    end
  endtask

  // Pulses start on the selected instances; c0 is the cycle count right
  // after the accepting edge, so the falling edge after E(k) sees c0+k.
  task automatic start_run(input bit s4, input bit s6, input bit s8, output int c0);
    @(posedge clk); #1;
    if4.start = s4; if6.start = s6; if8.start = s8;
    @(posedge clk); #1;
    if4.start = 1'b0; if6.start = 1'b0; if8.start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input int w, input int base, input int budget, input string name);
    int t = 0;
    while (done_cnt[w] <= base && t < budget) begin
      @(posedge clk);
      t++;
    end
    check_int(name, int'(done_cnt[w] > base), 1);
  endtask

  int  c0, base, n_before;
  int  db [3];
  bit  held_ok, found;
  logic [127:0] hold;

  initial begin
    vt.push_back(vec_t'{nk: 4, idx: 0,  mask: FULL, exp: KEY4});
    vt.push_back(vec_t'{nk: 4, idx: 1,  mask: FULL, exp: 128'ha0fafe1788542cb123a339392a6c7605});
    vt.push_back(vec_t'{nk: 4, idx: 2,  mask: FULL, exp: 128'hf2c295f27a96b9435935807a7359f67f});
    vt.push_back(vec_t'{nk: 4, idx: 3,  mask: FULL, exp: 128'h3d80477d4716fe3e1e237e446d7a883b});
    vt.push_back(vec_t'{nk: 4, idx: 4,  mask: FULL, exp: 128'hef44a541a8525b7fb671253bdb0bad00});
    vt.push_back(vec_t'{nk: 4, idx: 5,  mask: FULL, exp: 128'hd4d1c6f87c839d87caf2b8bc11f915bc});
    vt.push_back(vec_t'{nk: 4, idx: 6,  mask: FULL, exp: 128'h6d88a37a110b3efddbf98641ca0093fd});
    vt.push_back(vec_t'{nk: 4, idx: 7,  mask: FULL, exp: 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f});
    vt.push_back(vec_t'{nk: 4, idx: 8,  mask: FULL, exp: 128'head27321b58dbad2312bf5607f8d292f});
    vt.push_back(vec_t'{nk: 4, idx: 9,  mask: FULL, exp: 128'hac7766f319fadc2128d12941575c006e});
    vt.push_back(vec_t'{nk: 4, idx: 10, mask: FULL, exp: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
    vt.push_back(vec_t'{nk: 6, idx: 0,  mask: FULL, exp: KEY6[191:64]});
    vt.push_back(vec_t'{nk: 6, idx: 1,  mask: W2,   exp: 128'h0000_0000_0000_0000_fe0c91f7_0000_0000});
    vt.push_back(vec_t'{nk: 6, idx: 12, mask: FULL, exp: 128'he98ba06f448c773c8ecc720401002202});
    vt.push_back(vec_t'{nk: 8, idx: 0,  mask: FULL, exp: KEY8[255:128]});
    vt.push_back(vec_t'{nk: 8, idx: 1,  mask: FULL, exp: KEY8[127:0]});
    vt.push_back(vec_t'{nk: 8, idx: 2,  mask: FULL, exp: 128'h9ba354118e6925afa51a8b5f2067fcde});
    vt.push_back(vec_t'{nk: 8, idx: 3,  mask: W0,   exp: 128'ha8b09c1a_0000_0000_0000_0000_0000_0000});
    vt.push_back(vec_t'{nk: 8, idx: 14, mask: FULL, exp: 128'hfe4890d1e6188d0b046df344706c631e});

    rst = 1'b1;
    if4.start = 1'b0; if4.key_in = KEY4; if4.rk_ready = 1'b1;
    if6.start = 1'b0; if6.key_in = KEY6; if6.rk_ready = 1'b1;
    if8.start = 1'b0; if8.key_in = KEY8; if8.rk_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_int("rst_rk_valid", int'(if4.rk_valid), 0);
    check_int("rst_busy", int'(if4.busy), 0);
    check_int("rst_done", int'(if4.done), 0);
    check("rst_rk_data", if4.rk_data, '0);
    check_int("rst_rk_index", int'(if4.rk_index), 0);
    check_int("rst_nk8_rk_valid", int'(if8.rk_valid), 0);
    #1 rst = 1'b0;

    // All three key sizes, rk_ready tied high.
    base = recs.size();
    db   = done_cnt;
    start_run(1'b1, 1'b1, 1'b1, c0);
    check_int("busy_after_start", int'(if4.busy), 1);
    wait_done(0, db[0], 200, "nk4_done_timeout");
    wait_done(1, db[1], 200, "nk6_done_timeout");
    wait_done(2, db[2], 200, "nk8_done_timeout");
    repeat (5) @(posedge clk);
    scan(base);
    check_int("nk4_count", got_n[0], 11);
    check_int("nk6_count", got_n[1], 13);
    check_int("nk8_count", got_n[2], 15);
    check_int("nk4_order", int'(order_ok[0]), 1);
    check_int("nk6_order", int'(order_ok[1]), 1);
    check_int("nk8_order", int'(order_ok[2]), 1);
    check_int("nk4_rk1_latency", rk1_cyc, c0 + 8);
    check_int("nk4_done_once", done_cnt[0] - db[0], 1);
    check_int("nk6_done_once", done_cnt[1] - db[1], 1);
    check_int("nk8_done_once", done_cnt[2] - db[2], 1);
    check_int("nk4_done_cycle", done_cyc[0], c0 + 45);
    check_int("nk6_done_cycle", done_cyc[1], c0 + 53);
    check_int("nk8_done_cycle", done_cyc[2], c0 + 61);
    check_int("idle_busy", int'(if4.busy), 0);
    apply_table(4, "run");
    apply_table(6, "run");
    apply_table(8, "run");

    // Backpressure on round key 1. Edges E9..E18 see rk_ready low; words
    // 8..10 are still produced at E9..E11, word 11 waits at E12..E18 and is
    // produced at E19, so everything after it shifts by 7 cycles.
    base = recs.size();
    db   = done_cnt;
    start_run(1'b1, 1'b0, 1'b0, c0);
    repeat (8) @(posedge clk);
    #1;
    if4.rk_ready = 1'b0;
    check_int("bp_rk1_valid", int'(if4.rk_valid), 1);
    check_int("bp_rk1_index", int'(if4.rk_index), 1);
    hold    = if4.rk_data;
    held_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (!(if4.rk_valid && if4.rk_index == 4'd1 && if4.rk_data === hold)) held_ok = 1'b0;
    end
    if4.rk_ready = 1'b1;
    check_int("bp_held_stable", int'(held_ok), 1);
    wait_done(0, db[0], 200, "bp_done_timeout");
    repeat (5) @(posedge clk);
    scan(base);
    check_int("bp_count", got_n[0], 11);
    check_int("bp_order", int'(order_ok[0]), 1);
    check_int("bp_done_cycle", done_cyc[0], c0 + 45 + 7);
    apply_table(4, "bp");

    // Extra start during GEN is ignored; reset while round key 5 is valid.
    start_run(1'b1, 1'b0, 1'b0, c0);
    repeat (3) @(posedge clk);
    #1;
    if4.key_in = KEY4B;
    if4.start  = 1'b1;
    @(posedge clk); #1;
    if4.start  = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(posedge clk); #1;
      if (if4.rk_valid && if4.rk_index == 4'd5) found = 1'b1;
    end
    check_int("abort_rk5_seen", int'(found), 1);
    check("abort_rk5_data", if4.rk_data, 128'hd4d1c6f87c839d87caf2b8bc11f915bc);
    #2 rst = 1'b1;
    #1;
    check_int("abort_rk_valid", int'(if4.rk_valid), 0);
    check_int("abort_busy", int'(if4.busy), 0);
    check_int("abort_done", int'(if4.done), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_before = recs.size();
    repeat (10) @(posedge clk);
    #1;
    check_int("abort_no_more_keys", recs.size(), n_before);
    check_int("abort_still_idle", int'(if4.busy), 0);

    base = recs.size();
    db   = done_cnt;
    start_run(1'b1, 1'b0, 1'b0, c0);
    wait_done(0, db[0], 200, "newkey_done_timeout");
    repeat (5) @(posedge clk);
    scan(base);
    check_int("newkey_count", got_n[0], 11);
    check("newkey_rk0", got[0][0], KEY4B);
    check("newkey_rk10", got[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // rk_ready toggling every cycle.
    if4.key_in = KEY4;
    base = recs.size();
    db   = done_cnt;
    start_run(1'b1, 1'b0, 1'b0, c0);
    for (int t = 0; t < 400 && done_cnt[0] <= db[0]; t++) begin
      @(posedge clk); #1;
      if4.rk_ready = ~if4.rk_ready;
    end
    check_int("tog_done_seen", int'(done_cnt[0] > db[0]), 1);
    if4.rk_ready = 1'b1;
    repeat (5) @(posedge clk);
    scan(base);
    check_int("tog_count", got_n[0], 11);
    check_int("tog_order", int'(order_ok[0]), 1);
    check_int("tog_done_once", done_cnt[0] - db[0], 1);
    apply_table(4, "tog");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
